// File: rtl/paddle_pkg.sv
// Shared constants and quadrature phase types for the paddle_bank encoder pipeline.
// Gray order of the {a,b} phase is 00 -> 01 -> 11 -> 10 -> 00 (forward direction).
package paddle_pkg;

    localparam int DEF_POS_MIN   = 0;
    localparam int DEF_POS_MAX   = 400;
    localparam int DEF_POS_RESET = 200;
    localparam int DEF_STEP      = 4;
    localparam int ACCEL_THRESH  = 4;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_FWD,
        DIR_REV,
        DIR_ILLEGAL
    } dir_e;

    function automatic phase_e phase_fwd(input phase_e p);
        case (p)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

    // Classifies one filtered phase transition; a two-bit jump has no direction.
    function automatic dir_e phase_dir(input phase_e prev, input phase_e cur);
        if (cur == prev)            return DIR_NONE;
        if (cur == phase_fwd(prev)) return DIR_FWD;
        if (prev == phase_fwd(cur)) return DIR_REV;
        return DIR_ILLEGAL;
    endfunction

endpackage

// File: rtl/paddle_bank_if.sv
// Encoder inputs, frame tick and paddle outputs of paddle_bank, bundled for port hookup.
// The master side drives encoders and the tick; the slave side is the paddle controller.
interface paddle_bank_if #(
    parameter int CHANNELS = 2,
    parameter int POS_W    = 10
);

    logic [CHANNELS-1:0]       enc_a;
    logic [CHANNELS-1:0]       enc_b;
    logic                      frame_tick;
    logic [CHANNELS*POS_W-1:0] pos;
    logic [CHANNELS-1:0]       moved;

    modport master (
        output enc_a,
        output enc_b,
        output frame_tick,
        input  pos,
        input  moved
    );

    modport slave (
        input  enc_a,
        input  enc_b,
        input  frame_tick,
        output pos,
        output moved
    );

endinterface

// File: rtl/paddle_bank_quad_decoder.sv
// One encoder channel: 2-flop synchroniser, glitch filter, Gray decoder and a
// saturating signed detent accumulator that the frame logic clears via acc_clr_i.
module quad_decoder
    import paddle_pkg::*;
#(
    parameter int FILT  = 2,
    parameter int ACC_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_a_i,
    input  logic                    enc_b_i,
    input  logic                    acc_clr_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int CNT_W = $clog2(FILT + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    phase_e sync1_q, sync2_q;
    phase_e cand_q, cand_d;
    phase_e filt_q, filt_d;
    phase_e prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_base;
    dir_e dir;

    // NOTE: every register here is written with <= so all flops sample the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= PH_00;
            sync2_q <= PH_00;
            cand_q  <= PH_00;
            cnt_q   <= '0;
            filt_q  <= PH_00;
            prev_q  <= PH_00;
            acc_q   <= '0;
        end else begin
            sync1_q <= phase_e'({enc_a_i, enc_b_i});
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            acc_q   <= acc_d;
        end
    end

    // A new phase is accepted only after FILT identical samples that differ from filt_q.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        filt_d = filt_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != '0 && sync2_q == cand_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cand_d = sync2_q;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_W'(FILT)) begin
                filt_d = sync2_q;
                cnt_d  = '0;
            end
        end
    end

    // A clear and a step in the same cycle leave exactly that step in the accumulator.
    always_comb begin
        dir      = phase_dir(prev_q, filt_q);
        acc_base = acc_clr_i ? '0 : acc_q;
        acc_d    = acc_base;
        case (dir)
            DIR_FWD: if (acc_base != ACC_MAX) acc_d = acc_base + ACC_W'(1);
            DIR_REV: if (acc_base != ACC_MIN) acc_d = acc_base - ACC_W'(1);
            default: acc_d = acc_base;
        endcase
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/paddle_bank.sv
// Multi-channel quadrature paddle controller: per-frame detent accumulation, clamped
// positions updated only at frame_tick. Optional acceleration via PADDLE_BANK_ACCEL_EN.
module paddle_bank
    import paddle_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int POS_W     = 10,
    parameter int POS_MIN   = DEF_POS_MIN,
    parameter int POS_MAX   = DEF_POS_MAX,
    parameter int POS_RESET = DEF_POS_RESET,
    parameter int STEP      = DEF_STEP,
    parameter int FILT      = 2,
    parameter int ACC_W     = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    paddle_bank_if.slave  bus
);

    localparam int SUM_W = POS_W + ACC_W + 4;
    localparam logic signed [SUM_W-1:0] MIN_S  = SUM_W'(POS_MIN);
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(POS_MAX);
    localparam logic signed [SUM_W-1:0] STEP_S = SUM_W'(STEP);
`ifdef PADDLE_BANK_ACCEL_EN
    localparam logic signed [SUM_W-1:0] FAST_S = SUM_W'(2 * STEP);
    localparam logic signed [SUM_W-1:0] THR_S  = SUM_W'(ACCEL_THRESH);
`endif

    logic [CHANNELS-1:0][ACC_W-1:0] acc_w;
    logic [POS_W-1:0]               pos_q [CHANNELS];
    logic [POS_W-1:0]               pos_d [CHANNELS];
    logic [CHANNELS-1:0]            moved_q, moved_d;
    logic [CHANNELS*POS_W-1:0]      pos_flat;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        quad_decoder #(
            .FILT  (FILT),
            .ACC_W (ACC_W)
        ) u_dec (
            .clk       (clk),
            .rst_n     (rst_n),
            .enc_a_i   (bus.enc_a[i]),
            .enc_b_i   (bus.enc_b[i]),
            .acc_clr_i (bus.frame_tick),
            .acc_o     (acc_w[i])
        );
    end

    // The sum is formed wide enough that no detent count can wrap before the clamp.
    function automatic logic [POS_W-1:0] apply_move(input logic [POS_W-1:0] cur,
                                                    input logic [ACC_W-1:0] acc_raw);
        logic signed [SUM_W-1:0] cur_s;
        logic signed [SUM_W-1:0] acc_s;
        logic signed [SUM_W-1:0] step_s;
        logic signed [SUM_W-1:0] next_s;
        cur_s  = $signed({{(SUM_W-POS_W){1'b0}}, cur});
        acc_s  = SUM_W'($signed(acc_raw));
        step_s = STEP_S;
`ifdef PADDLE_BANK_ACCEL_EN
        if (acc_s >= THR_S || acc_s <= -THR_S) step_s = FAST_S;
`endif
        next_s = cur_s + acc_s * step_s;
        if (next_s < MIN_S) begin
            next_s = MIN_S;
        end else if (next_s > MAX_S) begin
            next_s = MAX_S;
        end
        return next_s[POS_W-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            pos_d[c]   = pos_q[c];
            moved_d[c] = 1'b0;
            if (bus.frame_tick) begin
                pos_d[c]   = apply_move(pos_q[c], acc_w[c]);
                moved_d[c] = (pos_d[c] != pos_q[c]);
            end
        end
    end

    // NOTE: the position array is a handful of flops, not a RAM, so it is reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pos_q[c] <= POS_W'(POS_RESET);
            end
            moved_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                pos_q[c] <= pos_d[c];
            end
            moved_q <= moved_d;
        end
    end

    always_comb begin
        pos_flat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pos_flat[c*POS_W +: POS_W] = pos_q[c];
        end
    end

    assign bus.pos   = pos_flat;
    assign bus.moved = moved_q;

endmodule
